// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch SRAM controller.
//   state_e      : controller mode (LOAD after reset, RUN, DRAIN)
//   DEPTH_DEF    : default SRAM depth in 32-bit words
//   AW_DEF       : default word-index width, log2(DEPTH_DEF)
//   addr_legal() : byte address is word aligned and inside the SRAM window
//   word_index() : byte address to zero-extended word index
package ifetch_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEPTH_DEF = 128;
  localparam int unsigned AW_DEF    = 7;

  // The offset is taken modulo 2^64, so addresses below the base wrap to a
  // huge offset and fail the range test.
  function automatic logic addr_legal(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input int unsigned depth);
    logic [63:0] off;
    off = addr - base;
    return (off[1:0] == 2'b00) && (off < (64'(depth) << 2));
  endfunction

  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned aw);
    logic [63:0] off;
    logic [63:0] mask;
    off  = addr - base;
    mask = (64'd1 << aw) - 64'd1;
    return (off >> 2) & mask;
  endfunction

endpackage

// File: rtl/ifetch_sram_ctrl_if.sv
// Bundle of the loader, fetch and SRAM port signals of ifetch_sram_ctrl.
//   slave  : the controller's view (loader/fetch requests in, SRAM strobes out)
//   master : the environment's view (loader, CPU fetch stage, SRAM)
interface ifetch_sram_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [63:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_err;
  logic        reload;
  logic        fetch_req_valid;
  logic        fetch_req_ready;
  logic [63:0] fetch_pc;
  logic        fetch_flush;
  logic        fetch_resp_valid;
  logic        fetch_resp_ready;
  logic [31:0] fetch_resp_inst;
  logic        fetch_resp_err;
  logic        inst_sram_en;
  logic [63:0] inst_sram_addr;
  logic        inst_sram_wen;
  logic [63:0] inst_sram_waddr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport slave (
    input  load_valid, load_addr, load_data, load_done, reload,
           fetch_req_valid, fetch_pc, fetch_flush, fetch_resp_ready,
           inst_sram_rdata,
    output load_ready, load_err, fetch_req_ready, fetch_resp_valid,
           fetch_resp_inst, fetch_resp_err, inst_sram_en, inst_sram_addr,
           inst_sram_wen, inst_sram_waddr, inst_sram_wdata
  );

  modport master (
    output load_valid, load_addr, load_data, load_done, reload,
           fetch_req_valid, fetch_pc, fetch_flush, fetch_resp_ready,
           inst_sram_rdata,
    input  load_ready, load_err, fetch_req_ready, fetch_resp_valid,
           fetch_resp_inst, fetch_resp_err, inst_sram_en, inst_sram_addr,
           inst_sram_wen, inst_sram_waddr, inst_sram_wdata
  );
endinterface

// File: rtl/ifetch_resp_skid.sv
// Single-entry fetch response buffer.
//   i_accept/i_legal : a request was accepted this cycle and whether it hit SRAM
//   i_flush          : drop any pending response (and the read now in flight)
//   i_rdata          : registered SRAM read data, valid the cycle after the read
//   i_ready          : consumer accepts the response
//   o_valid/o_inst/o_err : response presented to the fetch stage
// In the first response cycle the SRAM data is bypassed straight through; if
// that cycle stalls, the word is captured so later cycles see a stable value
// after the SRAM output has returned to 0.
module ifetch_resp_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_accept,
  input  logic        i_legal,
  input  logic        i_flush,
  input  logic [31:0] i_rdata,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic        o_err
);

  logic        r_valid;
  logic        r_fresh;   // first response cycle: data comes from the SRAM
  logic        r_legal;
  logic        r_err;
  logic [31:0] r_hold;
  logic [31:0] w_inst;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_fresh <= 1'b0;
      r_legal <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= 32'h0;
    end else begin
      if (i_flush)                r_valid <= 1'b0;
      else if (i_accept)          r_valid <= 1'b1;
      else if (r_valid && i_ready) r_valid <= 1'b0;

      r_fresh <= i_accept;
      if (i_accept) begin
        r_legal <= i_legal;
        r_err   <= !i_legal;
      end

      if (r_valid && r_fresh && !i_ready)
        r_hold <= r_legal ? i_rdata : 32'h0;
    end
  end

  assign w_inst  = r_fresh ? (r_legal ? i_rdata : 32'h0) : r_hold;
  // Flush hides the response in the same cycle so it can never handshake.
  assign o_valid = r_valid && !i_flush;
  assign o_inst  = o_valid ? w_inst : 32'h0;
  assign o_err   = o_valid && r_err;

endmodule

// File: rtl/ifetch_sram_ctrl.sv
// Sequences the single-port instruction SRAM between a program loader and
// the CPU fetch stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   io_bus     : loader write handshake, load_done/reload pulses, fetch
//                request/response handshakes, flush, and the SRAM ports
// LOAD admits loader writes (0-cycle to wen); RUN serves fetches with one
// outstanding read; DRAIN waits for the pending response before LOAD.
module ifetch_sram_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  ifetch_sram_ctrl_if.slave  io_bus
);

  state_e      r_state;
  logic        r_load_err;

  logic        w_load_fire;
  logic        w_load_legal;
  logic [63:0] w_load_idx;
  logic        w_req_ready;
  logic        w_req_fire;
  logic        w_req_legal;
  logic [63:0] w_req_idx;
  logic        w_resp_valid;
  logic [31:0] w_resp_inst;
  logic        w_resp_err;

  assign w_load_legal = addr_legal(io_bus.load_addr, BASE_ADDR, DEPTH);
  assign w_load_idx   = word_index(io_bus.load_addr, BASE_ADDR, AW);
  assign w_req_legal  = addr_legal(io_bus.fetch_pc, BASE_ADDR, DEPTH);
  assign w_req_idx    = word_index(io_bus.fetch_pc, BASE_ADDR, AW);

  assign w_load_fire  = (r_state == LOAD) && io_bus.load_valid;
  assign w_req_ready  = (r_state == RUN) && !io_bus.reload && !io_bus.fetch_flush &&
                        (!w_resp_valid || io_bus.fetch_resp_ready);
  assign w_req_fire   = w_req_ready && io_bus.fetch_req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOAD;
      r_load_err <= 1'b0;
    end else begin
      if (w_load_fire && !w_load_legal) r_load_err <= 1'b1;
      case (r_state)
        LOAD:    if (io_bus.load_done) r_state <= RUN;
        RUN:     if (io_bus.reload) r_state <= DRAIN;
        DRAIN:   if (!w_resp_valid || io_bus.fetch_resp_ready) r_state <= LOAD;
        default: r_state <= LOAD;
      endcase
    end
  end

  // SRAM strobes: writes only in LOAD, reads only in RUN, so never both.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    io_bus.inst_sram_wen   = 1'b0;
    io_bus.inst_sram_waddr = 64'h0;
    io_bus.inst_sram_wdata = 32'h0;
    io_bus.inst_sram_en    = 1'b0;
    io_bus.inst_sram_addr  = 64'h0;
    if (w_load_fire && w_load_legal) begin
      io_bus.inst_sram_wen   = 1'b1;
      io_bus.inst_sram_waddr = w_load_idx;
      io_bus.inst_sram_wdata = io_bus.load_data;
    end
    if (w_req_fire && w_req_legal) begin
      io_bus.inst_sram_en   = 1'b1;
      io_bus.inst_sram_addr = w_req_idx;
    end
  end

  ifetch_resp_skid u_resp_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_accept (w_req_fire),
    .i_legal  (w_req_legal),
    .i_flush  (io_bus.fetch_flush),
    .i_rdata  (io_bus.inst_sram_rdata),
    .i_ready  (io_bus.fetch_resp_ready),
    .o_valid  (w_resp_valid),
    .o_inst   (w_resp_inst),
    .o_err    (w_resp_err)
  );

  assign io_bus.load_ready       = (r_state == LOAD);
  assign io_bus.load_err         = r_load_err;
  assign io_bus.fetch_req_ready  = w_req_ready;
  assign io_bus.fetch_resp_valid = w_resp_valid;
  assign io_bus.fetch_resp_inst  = w_resp_inst;
  assign io_bus.fetch_resp_err   = w_resp_err;

endmodule

// File: tb/tb_ifetch_sram_ctrl.sv
// Self-checking bench for ifetch_sram_ctrl: directed loader/fetch vectors,
// a behavioural SRAM, and a response scoreboard drained by a monitor.
module tb_ifetch_sram_ctrl;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } resp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  resp_t exp_q[$];
  int    hs_cyc[$];
  resp_t mon_e;

  logic [31:0] mem [0:127];
  logic [31:0] gold [0:7] = '{32'h00000013, 32'h00100093, 32'hA0000002, 32'hA0000003,
                              32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007};

  ifetch_sram_ctrl_if bus ();

  ifetch_sram_ctrl #(
    .DEPTH     (128),
    .AW        (7),
    .BASE_ADDR (64'h0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read SRAM: data the cycle after en, 0 the cycle after !en.
  always @(posedge clk) begin
    if (bus.inst_sram_wen) mem[bus.inst_sram_waddr[6:0]] <= bus.inst_sram_wdata;
    bus.inst_sram_rdata <= bus.inst_sram_en ? mem[bus.inst_sram_addr[6:0]] : 32'h0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic resp_t mk(input logic [31:0] inst, input logic err);
    resp_t r;
    r.inst = inst;
    r.err  = err;
    return r;
  endfunction

  // Monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.fetch_resp_valid === 1'b1 && bus.fetch_resp_ready === 1'b1) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got inst 0x%0h err %0b, expected no response",
                 bus.fetch_resp_inst, bus.fetch_resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_inst", 64'(bus.fetch_resp_inst), 64'(mon_e.inst));
        check("resp_err",  64'(bus.fetch_resp_err),  64'(mon_e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic load_beat(input logic [63:0] addr, input logic [31:0] data, input logic done,
                           input logic exp_wen, input logic [63:0] exp_idx);
    bus.load_valid = 1'b1;
    bus.load_addr  = addr;
    bus.load_data  = data;
    bus.load_done  = done;
    mid();
    check("load_ready", 64'(bus.load_ready), 64'd1);
    check("sram_wen", 64'(bus.inst_sram_wen), 64'(exp_wen));
    if (exp_wen) begin
      check("sram_waddr", bus.inst_sram_waddr, exp_idx);
      check("sram_wdata", 64'(bus.inst_sram_wdata), 64'(data));
    end
    step();
    bus.load_valid = 1'b0;
    bus.load_done  = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] pc, input logic legal, input logic [63:0] idx,
                       input resp_t e, input logic keep);
    bus.fetch_req_valid = 1'b1;
    bus.fetch_pc        = pc;
    mid();
    check("req_ready", 64'(bus.fetch_req_ready), 64'd1);
    check("sram_en", 64'(bus.inst_sram_en), 64'(legal));
    if (legal) check("sram_addr", bus.inst_sram_addr, idx);
    if (keep) exp_q.push_back(e);
    step();
    bus.fetch_req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.load_valid = 1'b0;  bus.load_addr = 64'h0;  bus.load_data = 32'h0;
    bus.load_done = 1'b0;   bus.reload = 1'b0;      bus.fetch_req_valid = 1'b0;
    bus.fetch_pc = 64'h0;   bus.fetch_flush = 1'b0; bus.fetch_resp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_load_ready", 64'(bus.load_ready), 64'd1);
    check("rst_req_ready",  64'(bus.fetch_req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.fetch_resp_valid), 64'd0);
    check("rst_load_err",   64'(bus.load_err), 64'd0);
    check("rst_sram_en",    64'(bus.inst_sram_en), 64'd0);
    check("rst_sram_wen",   64'(bus.inst_sram_wen), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Program load, illegal beats, and load_done coinciding with a beat.
    load_beat(64'h0, 32'h00000013, 1'b0, 1'b1, 64'd0);
    load_beat(64'h4, 32'h00100093, 1'b0, 1'b1, 64'd1);
    check("load_err_clean", 64'(bus.load_err), 64'd0);
    load_beat(64'h2, 32'hDEADBEEF, 1'b0, 1'b0, 64'd0);
    check("load_err_misaligned", 64'(bus.load_err), 64'd1);
    load_beat(64'h200, 32'hDEADBEEF, 1'b0, 1'b0, 64'd0);
    for (int i = 2; i < 7; i++)
      load_beat(64'(i * 4), gold[i], 1'b0, 1'b1, 64'(i));
    load_beat(64'h1C, gold[7], 1'b1, 1'b1, 64'd7);
    check("run_load_ready", 64'(bus.load_ready), 64'd0);

    // Basic fetch and an illegal PC.
    fetch(64'h4, 1'b1, 64'd1, mk(32'h00100093, 1'b0), 1'b1);
    mid();
    check("latency_resp_valid", 64'(bus.fetch_resp_valid), 64'd1);
    step();
    fetch(64'h201, 1'b0, 64'd0, mk(32'h0, 1'b1), 1'b1);
    mid();
    check("illegal_sram_en", 64'(bus.inst_sram_en), 64'd0);
    step();

    // Backpressure: five stalled cycles, then one handshake.
    bus.fetch_resp_ready = 1'b0;
    fetch(64'h0, 1'b1, 64'd0, mk(32'h00000013, 1'b0), 1'b1);
    for (int i = 0; i < 5; i++) begin
      mid();
      check("stall_resp_valid", 64'(bus.fetch_resp_valid), 64'd1);
      check("stall_resp_inst", 64'(bus.fetch_resp_inst), 64'h13);
      check("stall_req_ready", 64'(bus.fetch_req_ready), 64'd0);
      check("stall_sram_en", 64'(bus.inst_sram_en), 64'd0);
      step();
    end
    bus.fetch_resp_ready = 1'b1;
    mid();
    step();
    mid();
    check("stall_released", 64'(bus.fetch_resp_valid), 64'd0);
    step();

    // Streaming: eight back-to-back fetches, responses on consecutive cycles.
    hs_cyc.delete();
    for (int i = 0; i < 8; i++)
      fetch(64'(i * 4), 1'b1, 64'(i), mk(gold[i], 1'b0), 1'b1);
    repeat (2) step();
    check("stream_count", 64'(hs_cyc.size()), 64'd8);
    if (hs_cyc.size() == 8)
      check("stream_span", 64'(hs_cyc[7] - hs_cyc[0]), 64'd7);

    // Flush the cycle after acceptance; a request offered then is refused.
    fetch(64'h4, 1'b1, 64'd1, mk(32'h0, 1'b0), 1'b0);
    bus.fetch_flush     = 1'b1;
    bus.fetch_req_valid = 1'b1;
    bus.fetch_pc        = 64'h8;
    mid();
    check("flush_resp_valid", 64'(bus.fetch_resp_valid), 64'd0);
    check("flush_req_ready", 64'(bus.fetch_req_ready), 64'd0);
    check("flush_sram_en", 64'(bus.inst_sram_en), 64'd0);
    step();
    bus.fetch_flush     = 1'b0;
    bus.fetch_req_valid = 1'b0;
    fetch(64'h8, 1'b1, 64'd2, mk(32'hA0000002, 1'b0), 1'b1);
    step();

    // Reload while a response is stalled: DRAIN until the handshake.
    bus.fetch_resp_ready = 1'b0;
    fetch(64'h0, 1'b1, 64'd0, mk(32'h00000013, 1'b0), 1'b1);
    bus.reload = 1'b1;
    mid();
    check("reload_req_ready", 64'(bus.fetch_req_ready), 64'd0);
    step();
    bus.reload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("drain_load_ready", 64'(bus.load_ready), 64'd0);
      check("drain_resp_valid", 64'(bus.fetch_resp_valid), 64'd1);
      step();
    end
    bus.fetch_resp_ready = 1'b1;
    mid();
    check("drain_last_load_ready", 64'(bus.load_ready), 64'd0);
    step();
    mid();
    check("reload_load_ready", 64'(bus.load_ready), 64'd1);
    check("reload_req_ready0", 64'(bus.fetch_req_ready), 64'd0);
    step();
    load_beat(64'h0, 32'h00000013, 1'b1, 1'b1, 64'd0);
    mid();
    check("rerun_req_ready", 64'(bus.fetch_req_ready), 64'd1);
    step();

    // Asynchronous reset in the middle of a stalled response.
    check("pre_reset_load_err", 64'(bus.load_err), 64'd1);
    bus.fetch_resp_ready = 1'b0;
    fetch(64'h4, 1'b1, 64'd1, mk(32'h0, 1'b0), 1'b0);
    mid();
    check("pre_reset_resp_valid", 64'(bus.fetch_resp_valid), 64'd1);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_load_ready", 64'(bus.load_ready), 64'd1);
    check("mid_rst_load_err", 64'(bus.load_err), 64'd0);
    check("mid_rst_req_ready", 64'(bus.fetch_req_ready), 64'd0);
    check("mid_rst_resp_valid", 64'(bus.fetch_resp_valid), 64'd0);
    check("mid_rst_resp_inst", 64'(bus.fetch_resp_inst), 64'd0);
    check("mid_rst_resp_err", 64'(bus.fetch_resp_err), 64'd0);
    check("mid_rst_sram_en", 64'(bus.inst_sram_en), 64'd0);
    check("mid_rst_sram_addr", bus.inst_sram_addr, 64'd0);
    check("mid_rst_sram_wen", 64'(bus.inst_sram_wen), 64'd0);
    check("mid_rst_sram_waddr", bus.inst_sram_waddr, 64'd0);
    check("mid_rst_sram_wdata", 64'(bus.inst_sram_wdata), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.fetch_resp_ready = 1'b1;

    // Out-of-range load sets the (freshly cleared) sticky error on its own.
    load_beat(64'h200, 32'h12345678, 1'b0, 1'b0, 64'd0);
    check("load_err_range", 64'(bus.load_err), 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
